hs_cdc_tx: RTL and testbench

HS_CDC_TX -- requirements
Module: hs_cdc_tx

---
 rtl/hs_cdc_tx.sv | 146 ++++++++++++++
 tb/tb_hs_cdc_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_cdc_tx.sv
// rtl/hs_cdc_tx.sv - 4-phase request/acknowledge CDC transmitter with synchronised ack
// Optional handshake timeout flag: define HS_CDC_TX_TIMEOUT_EN.
`timescale 1ns/1ps

module hs_cdc_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_tx,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              req,
    output logic [DATA_W-1:0] xdata,
    input  logic              ack_async,
    output logic              done,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_ack_sync;
    logic                    w_ack_s;
    logic                    r_req;
    logic                    w_req_nxt;
    logic [DATA_W-1:0]       r_xdata;
    logic [DATA_W-1:0]       w_xdata_nxt;
    logic                    r_done;
    logic                    w_done_nxt;

    // ack crosses from the far domain through a plain shift chain; only the last stage is used
    always_ff @(posedge clk_tx) begin
        if (rst) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_async};
        end
    end

    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // state and output registers; reset aborts any handshake in flight without a done
    always_ff @(posedge clk_tx) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_xdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_xdata <= w_xdata_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // next-state decode: word captured only in IDLE, so s_valid elsewhere is simply ignored
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_xdata_nxt = r_xdata;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_nxt = 1'b0;
                if (s_valid) begin
                    w_xdata_nxt = s_data;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = REQ_HI;
                end
            end
            REQ_HI: begin
                w_req_nxt = 1'b1;
                if (w_ack_s) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = REQ_LO;
                end
            end
            REQ_LO: begin
                w_req_nxt = 1'b0;
                if (!w_ack_s) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ready is decoded from state only; rst masks it so it reads low during reset
    assign s_ready = (r_state == IDLE) && !rst;
    assign req     = r_req;
    assign xdata   = r_xdata;
    assign done    = r_done;

`ifdef HS_CDC_TX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo_err;
    logic             w_tmo_run;
    logic             w_tmo_hit;

    // counter runs only while waiting in a handshake phase and never across a state change
    assign w_tmo_run = (r_state != IDLE) && (w_state_nxt == r_state);
    assign w_tmo_hit = w_tmo_run && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // phase-wait counter saturates at the limit so the sticky flag cannot be re-derived by wrap
    always_ff @(posedge clk_tx) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_tmo_cnt <= '0;
        end else if (w_tmo_run && (r_tmo_cnt != TMO_W'(TIMEOUT_CYC))) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // flag sets on the edge the counter reaches the limit and holds until reset; FSM keeps waiting
    always_ff @(posedge clk_tx) begin
        if (rst) begin
            r_tmo_err <= 1'b0;
        end else if (w_tmo_hit) begin
            r_tmo_err <= 1'b1;
        end
    end

    assign timeout_err = r_tmo_err;
`else
    // TIMEOUT_CYC stays referenced so builds without the timeout keep the same parameter list
    localparam logic TMO_NEVER = (TIMEOUT_CYC < 0);
    assign timeout_err = TMO_NEVER;
`endif

endmodule

// File: tb/tb_hs_cdc_tx.sv
// tb/tb_hs_cdc_tx.sv - scoreboard bench for hs_cdc_tx with directed and async-ack scenarios
`timescale 1ns/1ps

module tb_hs_cdc_tx;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int TC = 16;

    logic          clk_tx    = 1'b0;
    logic          clk_far   = 1'b0;
    logic          rst       = 1'b1;
    logic          s_valid   = 1'b0;
    logic [DW-1:0] s_data    = '0;
    logic          s_ready;
    logic          req;
    logic [DW-1:0] xdata;
    logic          ack_async;
    logic          done;
    logic          timeout_err;

    int n_assert  = 0;
    int n_fail    = 0;
    int done_cnt  = 0;
    int acc_cnt   = 0;
    int stab_err  = 0;
    int far_mode  = 0;

    logic          ack_m0  = 1'b0;
    logic          ack_m1  = 1'b0;
    logic          ack_man = 1'b0;
    logic          prev_req = 1'b0;
    logic [DW-1:0] prev_x   = '0;
    logic [DW-1:0] sb_q[$];

    always #5 clk_tx  = ~clk_tx;
    always #6 clk_far = ~clk_far;

    hs_cdc_tx #(.DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYC(TC)) dut (
        .clk_tx      (clk_tx),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .req         (req),
        .xdata       (xdata),
        .ack_async   (ack_async),
        .done        (done),
        .timeout_err (timeout_err)
    );

    assign ack_async = (far_mode == 0) ? ack_m0 :
                       (far_mode == 1) ? ack_m1 :
                       (far_mode == 3) ? ack_man : 1'b0;

    always @(negedge clk_tx) ack_m0 = req;
    always @(posedge clk_far) ack_m1 = req;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_tx);
        #1;
    endtask

    always @(posedge clk_tx) begin
        if (rst) begin
            sb_q.delete();
        end else if (s_valid && s_ready) begin
            sb_q.push_back(s_data);
            acc_cnt++;
        end
    end

    always @(negedge clk_tx) begin
        if (done === 1'b1) begin
            done_cnt++;
            n_assert++;
            assert (sb_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_underflow observed=done_with_empty_queue expected=queued_word");
            end
            if (sb_q.size() > 0) check("sb_xdata", xdata, sb_q.pop_front());
        end
        if (prev_req && req && (xdata !== prev_x)) stab_err++;
        prev_req = req;
        prev_x   = xdata;
    end

    initial begin
        int cyc;
        int base_d;
        int base_a;
        int last_a;

        // reset held 3 cycles with s_valid high
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_req", req, 0);
            check("rst_ready", s_ready, 0);
            check("rst_xdata", xdata, 0);
            check("rst_done", done, 0);
        end
        rst     = 1'b0;
        s_valid = 1'b0;
        #1;
        check("ready_after_rst", s_ready, 1);

        // single transfer, far side echoes req half a cycle later
        far_mode = 0;
        base_d   = done_cnt;
        s_valid  = 1'b1;
        s_data   = 8'hA5;
        tick();
        s_valid  = 1'b0;
        check("single_req", req, 1);
        check("single_xdata", xdata, 8'hA5);
        check("single_ready_busy", s_ready, 0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("single_latency", cyc, 2 * SS + 2);
        check("single_done", done, 1);
        check("single_xdata_at_done", xdata, 8'hA5);
        tick();
        check("single_done_pulse", done, 0);
        repeat (4) tick();
        check("single_done_count", done_cnt - base_d, 1);

        // ack glitch high while idle must be ignored
        far_mode = 3;
        base_d   = done_cnt;
        ack_man  = 1'b1;
        repeat (6) tick();
        check("glitch_req", req, 0);
        check("glitch_ready", s_ready, 1);
        check("glitch_done", done_cnt - base_d, 0);
        ack_man  = 1'b0;
        repeat (4) tick();
        far_mode = 0;

        // back-to-back with s_valid held high
        base_d  = done_cnt;
        base_a  = acc_cnt;
        s_data  = 8'h01;
        s_valid = 1'b1;
        cyc     = 0;
        while ((acc_cnt - base_a) < 4 && cyc < 200) begin
            tick();
            cyc++;
            s_data = 8'(acc_cnt - base_a + 1);
        end
        s_valid = 1'b0;
        cyc = 0;
        while ((done_cnt - base_d) < 4 && cyc < 100) begin
            tick();
            cyc++;
        end
        repeat (10) tick();
        check("b2b_accepts", acc_cnt - base_a, 4);
        check("b2b_dones", done_cnt - base_d, 4);
        check("b2b_sb_empty", sb_q.size(), 0);

        // reset asserted while in REQ_HI
        s_valid = 1'b1;
        s_data  = 8'h77;
        tick();
        s_valid = 1'b0;
        check("abort_req_before", req, 1);
        base_d  = done_cnt;
        rst     = 1'b1;
        tick();
        check("abort_req", req, 0);
        check("abort_done", done, 0);
        check("abort_ready", s_ready, 0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        check("abort_no_done", done_cnt - base_d, 0);
        check("abort_sb_flushed", sb_q.size(), 0);
        s_valid = 1'b1;
        s_data  = 8'h3C;
        tick();
        s_valid = 1'b0;
        check("post_abort_xdata", xdata, 8'h3C);
        cyc = 0;
        while ((done_cnt - base_d) < 1 && cyc < 40) begin
            tick();
            cyc++;
        end
        repeat (4) tick();
        check("post_abort_done", done_cnt - base_d, 1);

        // far side on its own 12 ns clock, 500 random words
        far_mode = 1;
        base_d   = done_cnt;
        base_a   = acc_cnt;
        last_a   = acc_cnt;
        stab_err = 0;
        s_valid  = 1'b0;
        cyc      = 0;
        while ((acc_cnt - base_a) < 500 && cyc < 30000) begin
            if (acc_cnt != last_a || !s_valid) begin
                last_a  = acc_cnt;
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = 8'($urandom);
            end
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        cyc = 0;
        while ((done_cnt - base_d) < 500 && cyc < 2000) begin
            tick();
            cyc++;
        end
        repeat (10) tick();
        check("async_accepts", acc_cnt - base_a, 500);
        check("async_dones", done_cnt - base_d, 500);
        check("async_sb_empty", sb_q.size(), 0);
        check("async_xdata_stable", stab_err, 0);

`ifdef HS_CDC_TX_TIMEOUT_EN
        // ack never returns: sticky flag after TC cycles in REQ_HI, then late ack completes
        far_mode = 2;
        repeat (6) tick();
        check("tmo_clear", timeout_err, 0);
        base_d  = done_cnt;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        tick();
        s_valid = 1'b0;
        repeat (TC - 1) tick();
        check("tmo_before", timeout_err, 0);
        tick();
        check("tmo_set", timeout_err, 1);
        repeat (5) tick();
        check("tmo_sticky", timeout_err, 1);
        check("tmo_req_held", req, 1);
        far_mode = 0;
        cyc = 0;
        while ((done_cnt - base_d) < 1 && cyc < 40) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        check("tmo_done", done_cnt - base_d, 1);
        check("tmo_after_done", timeout_err, 1);
`else
        check("tmo_tied_low", timeout_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
